pwm_sample_decoder: RTL and testbench
=====================================

# pwm_sample_decoder

Recovers fixed-period PWM audio frames from a single-bit line and outputs one `WIDTH`-bit sample per frame, with a valid pulse. It is the receive end of the synth's 1-bit `sigout` audio path. It sits in the verification/loopback path beside the synth core and in any downstream consumer of the PWM stream. Frame period is fixed at 2^`WIDTH` clocks. Sample value = number of high cycles in the frame.

## Interface
- `WIDTH`, 8: sample width. Frame period `PERIOD` = 2**`WIDTH` clocks (derived, not overridable).
- `SYNC_STAGES`, 2: synchronizer depth on `pwm_in` (minimum 2).

- `clk`  input  1  system clock, same domain as the synth core
- `nrst`  input  1  reset, asynchronous, active-low
- `en`  input  1  decoder enable; low forces HUNT
- `pwm_in`  input  1  PWM line, asynchronous to `clk`
- `sample`  output  `WIDTH`  last decoded sample, held between frames
- `sample_valid`  output  1  one-cycle pulse, `sample` updated this cycle
- `frame_err`  output  1  one-cycle pulse on a framing violation
- `locked`  output  1  high after the first good frame; cleared by error, HUNT or `!en`

## Operation
- Encoder contract: in a frame of value v, the line is high for cycles 0..v-1 and low for the remaining cycles. v is in 0..`PERIOD`-1, so the last cycle of every frame is low.
- `s_in` is the synchronized `pwm_in`. `rise` = `s_in` & ~`s_in_d`.
- States:
  - HUNT: wait for `rise`.
  - MEASURE: frame counter `cnt` (`WIDTH` bits) plus high accumulator `acc` (`WIDTH` bits).
- HUNT -> MEASURE on `rise` while `en` is high.
  - That cycle is frame cycle 0: `cnt`=0, `acc`=1.
- MEASURE, each cycle: `cnt`++ (wraps), `acc` += `s_in`.
- Frame end (`cnt`==`PERIOD`-1) with `s_in` low:
  - `sample`<=`acc`, pulse `sample_valid`, set `locked`.
  - The next cycle is cycle 0 of a new frame. `acc` restarts at `s_in` for that cycle.
  - A missing `rise` at cycle 0 is legal and means the new frame has value 0.
- Frame end with `s_in` high: pulse `frame_err`, clear `locked`, go to HUNT, discard `acc`.
- `rise` at `cnt` in 1..`PERIOD`-1, i.e. a mid-frame rise:
  - Pulse `frame_err`, clear `locked`, discard the frame.
  - Re-sync: this cycle becomes cycle 0, `acc`=1, stay in MEASURE.
- `acc` never overflows, since its maximum is `PERIOD`-1.
- `en` low: go to HUNT immediately, clear `locked`, hold `sample`, no pulses.
- Simultaneous events: frame end with `s_in` high takes priority and goes to HUNT. A rise at the wrap cycle is a normal frame start.

## Timing
- Reset values: `sample`=0, `sample_valid`=0, `frame_err`=0, `locked`=0, state HUNT, synchronizer flops 0.
- Pin-to-`s_in` latency: `SYNC_STAGES` cycles.
- `sample_valid` is registered: it rises the cycle after the frame-end cycle, `PERIOD` cycles after that frame's cycle 0.
- `locked` rises together with the first `sample_valid`. `frame_err` and the `locked` fall are registered and aligned with each other.
- Outputs do not depend combinationally on `pwm_in` or `en`.
- Reset asserted mid-frame: all state clears asynchronously. After release, the first frame is measured only from the next `rise`.

## Structure
- Shared package `tmnt_pkg`:
  - state enum `pwm_dec_state_t` {HUNT, MEASURE}
  - `SAMPLE_W` default 8, shared with the synth PWM generator
- One sub-module, `sync_bit`: a parameterized N-flop synchronizer reused for the pushbutton inputs.
- Counter, accumulator, FSM and output registers live in `pwm_sample_decoder`.

## Test plan
- Encoder drives 100 for 4 frames -> `sample_valid` every 256 cycles with `sample`=100; `locked`=1 from the first pulse; no `frame_err`.
- Frame sequence 100, 0, 255, 1 -> samples 100, 0, 255, 1 on consecutive pulses 256 cycles apart; the zero frame has no rise and keeps lock.
- Extra 1-cycle high glitch at cnt 50 of a value-20 frame -> `frame_err` pulse, `locked`=0, no sample for that frame; glitch is the new cycle 0.
- Line held high 300 cycles after lock -> `frame_err` at cnt 255, HUNT, `locked`=0; the next legal frame relocks after 256 cycles.
- `en` dropped mid-frame for 10 cycles, then raised -> `locked`=0, `sample` held; relocks one frame after the next rise.
- `nrst` pulsed low at cnt 128 -> all outputs 0 asynchronously; no `sample_valid` until a full frame after the next rise.

Source files
------------

// File: rtl/tmnt_pkg.sv
// Shared definitions for the synth audio path: PWM sample width and decoder state encoding.
package tmnt_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic {
        HUNT    = 1'b0,
        MEASURE = 1'b1
    } pwm_dec_state_t;

endpackage

// File: rtl/sync_bit.sv
// N-flop synchronizer for a single asynchronous bit; output is the last flop in the chain.
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/pwm_sample_decoder.sv
// Recovers fixed-period PWM frames (2**WIDTH clocks) from a 1-bit line; sample = high cycles per frame.
module pwm_sample_decoder
    import tmnt_pkg::*;
#(
    parameter int WIDTH       = SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             frame_err,
    output logic             locked
);

    localparam logic [WIDTH-1:0] LAST_CYC = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic s_in;
    logic s_in_d_q;
    logic rise;

    pwm_dec_state_t state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             sample_valid_q, sample_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] cur_cnt;
    logic [WIDTH-1:0] cur_acc;

    sync_bit #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (pwm_in),
        .q    (s_in)
    );

    assign rise = s_in & ~s_in_d_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        locked_d       = locked_q;

        // cnt_q/acc_q describe the previous cycle; this cycle's position and running total follow.
        cur_cnt = cnt_q + 1'b1;
        cur_acc = (cnt_q == LAST_CYC) ? WIDTH'(s_in) : acc_q + WIDTH'(s_in);

        if (!en) begin
            state_d  = HUNT;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = '0;
                        acc_d   = ONE;
                    end
                end
                MEASURE: begin
                    if (cur_cnt == LAST_CYC && s_in) begin
                        // Last cycle of a frame must be low; lost framing, hunt for a fresh rise.
                        state_d     = HUNT;
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                    end else if (rise && cur_cnt != '0) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        cnt_d       = '0;
                        acc_d       = ONE;
                    end else begin
                        cnt_d = cur_cnt;
                        acc_d = cur_acc;
                        if (cur_cnt == LAST_CYC) begin
                            sample_d       = cur_acc;
                            sample_valid_d = 1'b1;
                            locked_d       = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s_in_d_q       <= 1'b0;
            state_q        <= HUNT;
            cnt_q          <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            s_in_d_q       <= s_in;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
            locked_q       <= locked_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Bench for pwm_sample_decoder: frame-level reference model checked every cycle, plus directed literal checks.
module tb_pwm_sample_decoder;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 256;
    localparam int SYNC   = 2;

    logic             clk = 1'b0;
    logic             nrst;
    logic             en;
    logic             pwm_in;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             frame_err;
    logic             locked;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_sample_decoder #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .pwm_in       (pwm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works on whole frames as a list of line bits seen since the frame start.
    logic [SYNC:0]    h        = '0;
    logic             hunting  = 1'b1;
    logic [WIDTH-1:0] m_sample = '0;
    logic             m_valid  = 1'b0;
    logic             m_err    = 1'b0;
    logic             m_locked = 1'b0;
    logic             bits[$];
    logic             s, sp, m_rise;
    int               pos;
    int               ones;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            h        = '0;
            hunting  = 1'b1;
            m_sample = '0;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            m_locked = 1'b0;
            bits.delete();
        end else begin
            s       = h[SYNC-1];
            sp      = h[SYNC];
            m_rise  = s & ~sp;
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (!en) begin
                hunting  = 1'b1;
                m_locked = 1'b0;
                bits.delete();
            end else if (hunting) begin
                if (m_rise) begin
                    hunting = 1'b0;
                    bits.delete();
                    bits.push_back(1'b1);
                end
            end else begin
                pos = bits.size();
                if (pos == PERIOD - 1 && s) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                    hunting  = 1'b1;
                    bits.delete();
                end else if (m_rise && pos != 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                    bits.delete();
                    bits.push_back(1'b1);
                end else begin
                    bits.push_back(s);
                    if (bits.size() == PERIOD) begin
                        ones = 0;
                        foreach (bits[i]) ones += int'(bits[i]);
                        m_sample = WIDTH'(ones);
                        m_valid  = 1'b1;
                        m_locked = 1'b1;
                        bits.delete();
                    end
                end
            end
            h = {h[SYNC-1:0], pwm_in};
        end
    end

    // Scoreboard: every-cycle compare against the model, plus a log of delivered samples.
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               err_cnt = 0;

    always @(negedge clk) begin
        check("sample", 32'(sample), 32'(m_sample));
        check("sample_valid", 32'(sample_valid), 32'(m_valid));
        check("frame_err", 32'(frame_err), 32'(m_err));
        check("locked", 32'(locked), 32'(m_locked));
        if (sample_valid) got_q.push_back(sample);
        if (frame_err) err_cnt++;
    end

    task automatic drive_cycles(input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pwm_in = val;
        end
    endtask

    task automatic drive_frame(input int v);
        for (int i = 0; i < PERIOD; i++) begin
            @(posedge clk);
            #1;
            pwm_in = (i < v);
        end
    endtask

    initial begin
        nrst   = 1'b0;
        en     = 1'b1;
        pwm_in = 1'b0;
        exp_q  = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0, 8'd255, 8'd1,
                   8'd1, 8'd77, 8'd60, 8'd90, 8'd90};

        repeat (3) @(posedge clk);
        #1;
        check("reset_sample", 32'(sample), 32'd0);
        check("reset_valid", 32'(sample_valid), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        nrst = 1'b1;
        drive_cycles(1'b0, 4);

        // Steady frames of 100
        repeat (4) drive_frame(100);
        check("locked_after_steady", 32'(locked), 32'd1);

        // Mixed values including an empty frame
        drive_frame(100);
        drive_frame(0);
        drive_frame(255);
        drive_frame(1);

        // Value-20 frame with a glitch at cycle 50 that starts a new frame
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            pwm_in = (i < 20);
        end
        drive_frame(1);

        // Line stuck high for 300 cycles, then a legal frame
        drive_cycles(1'b1, 300);
        check("locked_after_stuck", 32'(locked), 32'd0);
        drive_cycles(1'b0, 3);
        drive_frame(77);

        // Enable dropped for 10 cycles mid-frame
        for (int i = 0; i < PERIOD; i++) begin
            @(posedge clk);
            #1;
            pwm_in = (i < 60);
            en     = !(i >= 100 && i < 110);
            if (i == 105) begin
                check("en_low_sample_held", 32'(sample), 32'd77);
                check("en_low_unlocked", 32'(locked), 32'd0);
            end
        end
        drive_frame(60);

        // Asynchronous reset at cnt 128
        for (int i = 0; i < PERIOD; i++) begin
            @(posedge clk);
            #1;
            pwm_in = (i < 90);
            if (i == 128) begin
                check("pre_reset_sample", 32'(sample), 32'd60);
                check("pre_reset_locked", 32'(locked), 32'd1);
                #2;
                nrst = 1'b0;
                #1;
                check("async_reset_sample", 32'(sample), 32'd0);
                check("async_reset_locked", 32'(locked), 32'd0);
                check("async_reset_valid", 32'(sample_valid), 32'd0);
            end
            if (i == 131) nrst = 1'b1;
        end
        drive_frame(90);
        drive_frame(90);
        drive_cycles(1'b0, 8);

        check("sample_count", 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check("sample_seq", 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("frame_err_count", 32'(err_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
